// File: rtl/key_press_conditioner.sv
// Key conditioner: synchronises raw active-low buttons, debounces them in CE ticks
// and emits one-clk press/release pulses. `KEYCOND_TIE_CANCEL_EN drops coincident presses.
module key_press_conditioner #(
    parameter int NUM_KEYS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_TICKS    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                CE,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_press
);
    localparam int CW = $clog2(DB_TICKS + 1);

    logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]       cnt_q  [NUM_KEYS];
    logic [CW-1:0]       cnt_d  [NUM_KEYS];
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] rise;
    logic                any_q, any_d;
    logic [NUM_KEYS-1:0] s;

    // Last synchroniser stage, inverted so that 1 means pressed.
    assign s = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
        end else begin
            sync_q[0] <= key_n;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
        end
    end

    always_comb begin
        level_d = level_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (CE) begin
                if (s[k] == level_q[k]) begin
                    cnt_d[k] = '0;
                end else if (int'(cnt_q[k]) + 1 >= DB_TICKS) begin
                    level_d[k] = s[k];
                    cnt_d[k]   = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
        rise      = level_d & ~level_q;
        release_d = level_q & ~level_d;
        press_d   = rise;
`ifdef KEYCOND_TIE_CANCEL_EN
        // Exact ties between players are resolved by letting nobody move.
        if ($countones(rise) > 1) press_d = '0;
`endif
        any_d = |press_d;
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign any_press   = any_q;
endmodule

// File: tb/tb_key_press_conditioner.sv
// Self-checking bench for key_press_conditioner: directed scenarios plus randomized
// key activity, all compared against a cycle-level behavioural model of the key rules.
module tb_key_press_conditioner;
    localparam int NK = 4;
    localparam int SS = 2;
    localparam int DB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          CE;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level, key_press, key_release;
    logic          any_press;

    always #5 clk = ~clk;

    key_press_conditioner #(.NUM_KEYS(NK), .SYNC_STAGES(SS), .DB_TICKS(DB)) dut (
        .clk(clk), .reset(reset), .CE(CE), .key_n(key_n),
        .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .any_press(any_press)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ce_phase = 0;
    bit ce_always = 1'b0;
    int cyc = 0;

    // Model state: raw history (index 0 newest), consecutive disagreeing tick counts, outputs.
    logic [NK-1:0] hist [SS];
    int            m_cnt [NK];
    logic [NK-1:0] m_level, m_press, m_rel;
    logic          m_any;

    task automatic tick();
        logic [NK-1:0] s, nl, pr, rl, kn;
        logic          rst, ce;
        int            nc [NK];
        kn  = key_n;
        rst = reset;
        ce  = CE;
        s   = ~hist[SS-1];
        nl  = m_level;
        for (int k = 0; k < NK; k++) begin
            nc[k] = m_cnt[k];
            if (ce) begin
                if (s[k] == m_level[k]) nc[k] = 0;
                else if (m_cnt[k] + 1 == DB) begin
                    nl[k] = s[k];
                    nc[k] = 0;
                end else nc[k] = m_cnt[k] + 1;
            end
        end
        pr = nl & ~m_level;
        rl = m_level & ~nl;
`ifdef KEYCOND_TIE_CANCEL_EN
        if ($countones(pr) > 1) pr = '0;
`endif
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < SS; i++) hist[i] = '1;
            for (int k = 0; k < NK; k++) m_cnt[k] = 0;
            m_level = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
        end else begin
            for (int i = SS-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = kn;
            for (int k = 0; k < NK; k++) m_cnt[k] = nc[k];
            m_level = nl; m_press = pr; m_rel = rl; m_any = |pr;
        end
        #1;
        cyc++;
        ce_phase++;
        CE = ce_always ? 1'b1 : (ce_phase % 4 == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key_n = '1;
        repeat (3) tick();
        n_cmp++;
        if ({key_level, key_press, key_release, any_press} !== '0) begin
            n_bad++;
            $display("FAIL reset_values got lvl=%b prs=%b rel=%b any=%b want all 0",
                     key_level, key_press, key_release, any_press);
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_cmp++;
            if ({key_level, key_press, key_release, any_press} !== '0) begin
                n_bad++;
                $display("FAIL idle_quiet cyc=%0d got lvl=%b prs=%b rel=%b any=%b want all 0",
                         cyc, key_level, key_press, key_release, any_press);
            end
        end
    endtask

    task automatic test_press();
        int first = -1, np = 0, na = 0, other = 0;
        key_n = 4'b1110;
        for (int i = 1; i <= 24; i++) begin
            tick();
            n_cmp++;
            if ({key_level, key_press, key_release, any_press} !== {m_level, m_press, m_rel, m_any}) begin
                n_bad++;
                $display("FAIL press_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                         key_level, key_press, key_release, any_press, m_level, m_press, m_rel, m_any);
            end
            if (key_level[0] && first < 0) first = i;
            if (key_press[0]) np++;
            if (any_press) na++;
            if ((key_press & 4'b1110) != 0 || key_release != 0) other++;
        end
        n_cmp++;
        if (first < 1 || first > 16) begin
            n_bad++;
            $display("FAIL press_latency got %0d clks want 1..16", first);
        end
        n_cmp++;
        if (np != 1 || na != 1 || other != 0) begin
            n_bad++;
            $display("FAIL press_pulse got press0=%0d any=%0d other=%0d want 1 1 0", np, na, other);
        end
    endtask

    task automatic test_bounce();
        int np = 0;
        int first = -1;
        key_n = 4'b1100;
        for (int i = 0; i < 30; i++) begin
            if (i == 6) key_n[1] = 1'b1;
            if (i == 10) key_n[1] = 1'b0;
            tick();
            n_cmp++;
            if ({key_level, key_press, key_release, any_press} !== {m_level, m_press, m_rel, m_any}) begin
                n_bad++;
                $display("FAIL bounce_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                         key_level, key_press, key_release, any_press, m_level, m_press, m_rel, m_any);
            end
            if (key_press[1]) np++;
            if (key_level[1] && first < 0) first = i;
        end
        n_cmp++;
        if (np != 1 || first < 12) begin
            n_bad++;
            $display("FAIL bounce_single got pulses=%0d first_level_at=%0d want 1 and >=12", np, first);
        end
    endtask

    task automatic test_release();
        int nr = 0, np = 0;
        key_n = 4'b1111;
        for (int i = 0; i < 24; i++) begin
            tick();
            n_cmp++;
            if ({key_level, key_press, key_release, any_press} !== {m_level, m_press, m_rel, m_any}) begin
                n_bad++;
                $display("FAIL release_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                         key_level, key_press, key_release, any_press, m_level, m_press, m_rel, m_any);
            end
            if (key_release[0]) nr++;
            if (key_press != 0) np++;
        end
        n_cmp++;
        if (nr != 1 || np != 0 || key_level !== 4'b0000) begin
            n_bad++;
            $display("FAIL release_pulse got rel0=%0d press=%0d lvl=%b want 1 0 0000", nr, np, key_level);
        end
    endtask

    task automatic test_tie();
        int n_pair = 0, n_other = 0;
        key_n = 4'b0110;
        for (int i = 0; i < 24; i++) begin
            tick();
            n_cmp++;
            if ({key_level, key_press, key_release, any_press} !== {m_level, m_press, m_rel, m_any}) begin
                n_bad++;
                $display("FAIL tie_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                         key_level, key_press, key_release, any_press, m_level, m_press, m_rel, m_any);
            end
            if (key_press == 4'b1001 && any_press) n_pair++;
            else if (key_press != 0 || any_press) n_other++;
        end
        n_cmp++;
`ifdef KEYCOND_TIE_CANCEL_EN
        if (n_pair != 0 || n_other != 0 || key_level !== 4'b1001) begin
            n_bad++;
            $display("FAIL tie_cancel got pairs=%0d other=%0d lvl=%b want 0 0 1001", n_pair, n_other, key_level);
        end
`else
        if (n_pair != 1 || n_other != 0 || key_level !== 4'b1001) begin
            n_bad++;
            $display("FAIL tie_both got pairs=%0d other=%0d lvl=%b want 1 0 1001", n_pair, n_other, key_level);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int waited = 0, first = -1, np = 0;
        key_n = 4'b1111;
        repeat (24) tick();
        key_n = 4'b1011;
        while (m_cnt[2] != 2 && waited < 40) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (m_cnt[2] != 2 || key_level[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL midcount_reach got waited=%0d lvl2=%b want count 2 before accept", waited, key_level[2]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({key_level, key_press, key_release, any_press} !== '0) begin
            n_bad++;
            $display("FAIL midcount_reset got lvl=%b prs=%b rel=%b any=%b want all 0",
                     key_level, key_press, key_release, any_press);
        end
        for (int i = 1; i <= 24; i++) begin
            tick();
            n_cmp++;
            if ({key_level, key_press, key_release, any_press} !== {m_level, m_press, m_rel, m_any}) begin
                n_bad++;
                $display("FAIL midcount_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                         key_level, key_press, key_release, any_press, m_level, m_press, m_rel, m_any);
            end
            if (key_press[2]) begin
                np++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (np != 1 || first < 3 || first > 16) begin
            n_bad++;
            $display("FAIL midcount_fresh got pulses=%0d first=%0d want 1 and 3..16", np, first);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            ce_always = (i >= 1500);
            reset = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 5) == 0) key_n[k] = ~key_n[k];
            tick();
            n_cmp++;
            if ({key_level, key_press, key_release, any_press} !== {m_level, m_press, m_rel, m_any}) begin
                n_bad++;
                $display("FAIL random_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                         key_level, key_press, key_release, any_press, m_level, m_press, m_rel, m_any);
            end
        end
        reset = 1'b0;
        ce_always = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        CE    = 1'b0;
        key_n = '1;
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_tie();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
